// File: rtl/mux16_sched_pkg.sv
// Shared constants, FSM state type and grant helper for the 16-way mux scheduler.
package mux16_sched_pkg;

  localparam int unsigned NUM_REQ = 16;
  localparam int unsigned SEL_W   = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux16_rr_pick.sv
// Combinational rotate-priority encoder: first set req bit searching last+1, last+2, ... with wrap.
module mux16_rr_pick
  import mux16_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [SEL_W-1:0] cand;

  // NOTE: every output gets a default first so no path through the loop can infer a latch.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // Offset NUM_REQ truncates to 0, so last itself is examined last (lowest priority).
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin owner of a shared 16:1 mux select; optional forced release under MUX16_TIMEOUT_EN.
module mux16_rr_sched
  import mux16_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic               timeout
);

  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("mux16_rr_sched: MAX_HOLD must be >= 2");
  end

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;
  logic               force_rel;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;

  mux16_rr_pick u_pick (
    .req  (req),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef MUX16_TIMEOUT_EN
  localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // hold_cnt is 0 in the first BUSY cycle, so MAX_HOLD-1 marks BUSY cycle MAX_HOLD.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    force_rel  = 1'b0;
    if (state_q == IDLE) begin
      hold_cnt_d = '0;
    end else begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
      force_rel  = (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) && !done && req[sel_q];
    end
    timeout_d = force_rel;
  end
`else
  always_comb begin
    force_rel = 1'b0;
    timeout_d = 1'b0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    unique case (state_q)
      IDLE: begin
        if (en && pick_any) begin
          sel_d       = pick_idx;
          gnt_d       = onehot(pick_idx);
          gnt_valid_d = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Owner finishing, abandoning req, or overstaying all release identically.
        if (done || !req[sel_q] || force_rel) begin
          last_d      = sel_q;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: last resets to NUM_REQ-1 so the first grant after reset goes to the lowest index.
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      last_q      <= SEL_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef MUX16_TIMEOUT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
`ifdef MUX16_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
